// File: rtl/inc1_share_arb.sv
// inc1_share_arb
//   Round-robin arbiter in front of a single shared 24-bit incrementer.
//   Up to N_REQ requesters offer an operand and a carry-in. One request is
//   granted per cycle, and {cout, data} = operand + cin is registered into a
//   one-entry result buffer with a valid/ready handshake. A saturating
//   counter tracks the accepted requests that produced a carry-out.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   req_valid  : [N_REQ]    per-requester request valid
//   req_data   : [N_REQ*24] per-requester operand, requester i at [24i+23:24i]
//   req_cin    : [N_REQ]    per-requester carry-in (increment enable)
//   req_ready  : [N_REQ]    one-hot grant, combinational
//   rsp_valid  : result register holds a valid result
//   rsp_ready  : consumer accepts the result
//   rsp_data   : [24] registered result
//   rsp_cout   : registered carry-out
//   rsp_id     : [clog2(N_REQ)] index of the requester that owns the result
//   ovf_cnt    : [CNT_W] saturating count of accepted results with cout=1
module inc1_share_arb #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 16,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*24-1:0]   req_data,
   input  logic [N_REQ-1:0]      req_cin,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [23:0]           rsp_data,
   output logic                  rsp_cout,
   output logic [ID_W-1:0]       rsp_id,
   output logic [CNT_W-1:0]      ovf_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] ptr_nxt;
   logic [ID_W-1:0] grant_idx;
   logic            grant_hit;
   logic            can_accept;
   logic            accept;
   logic [23:0]     op_sel;
   logic            cin_sel;
   logic [24:0]     inc_res;

   // Round-robin search starting at ptr; the first valid index wins.
   always_comb begin
      int unsigned cand;
      grant_idx = '0;
      grant_hit = 1'b0;
      cand      = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = (32'(ptr) + k) % N_REQ;
         if (!grant_hit && req_valid[cand]) begin
            grant_hit = 1'b1;
            grant_idx = ID_W'(cand);
         end
      end
   end

   // The buffer can be refilled when empty, or when full and drained this cycle.
   assign can_accept = !rst && ((state == EMPTY) || rsp_ready);
   assign accept     = can_accept && grant_hit;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign ptr_nxt = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // The only incrementer: operand and carry-in are muxed by the grant.
   assign op_sel  = req_data[grant_idx*24 +: 24];
   assign cin_sel = req_cin[grant_idx];
   assign inc_res = {1'b0, op_sel} + 25'(cin_sel);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (accept) state_nxt = FULL;
         end
         FULL: begin
            if (accept)         state_nxt = FULL;
            else if (rsp_ready) state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   assign rsp_valid = (state == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_data <= '0;
         rsp_cout <= 1'b0;
         rsp_id   <= '0;
         ptr      <= '0;
         ovf_cnt  <= '0;
      end else if (accept) begin
         rsp_data <= inc_res[23:0];
         rsp_cout <= inc_res[24];
         rsp_id   <= grant_idx;
         ptr      <= ptr_nxt;
         if (inc_res[24] && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
         end
      end
   end

endmodule
